// File: rtl/tod_counter.sv
// 24-hour BCD time-of-day counter with button-driven hour/minute set mode.
// Emits a registered one-cycle day_carry on midnight rollover.
module tod_counter #(
  parameter logic SYNC_RESET_VAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hour1,
  output logic [3:0] hour0,
  output logic [3:0] min1,
  output logic [3:0] min0,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic [1:0] mode,
  output logic       day_carry
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } mode_e;

  mode_e      mode_q, mode_d;
  logic [3:0] h1_q, h0_q, m1_q, m0_q, s1_q, s0_q;
  logic [3:0] h1_d, h0_d, m1_d, m0_d, s1_d, s0_d;
  logic       carry_q, carry_d;

  logic       bm_s0_q, bm_s1_q, bm_prev_q;
  logic       bi_s0_q, bi_s1_q, bi_prev_q;
  logic       mode_press, inc_press;

  // {wrap, tens, units} for a 00-59 field
  function automatic logic [8:0] inc60(input logic [3:0] t,
                                       input logic [3:0] u);
    logic [8:0] r;
    if (u != 4'd9)      r = {1'b0, t, u + 4'd1};
    else if (t != 4'd5) r = {1'b0, t + 4'd1, 4'd0};
    else                r = {1'b1, 4'd0, 4'd0};
    return r;
  endfunction

  function automatic logic [7:0] inc24(input logic [3:0] t,
                                       input logic [3:0] u);
    logic [7:0] r;
    if (t == 4'd2 && u == 4'd3) r = 8'h00;
    else if (u != 4'd9)         r = {t, u + 4'd1};
    else                        r = {t + 4'd1, 4'd0};
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bm_s0_q   <= SYNC_RESET_VAL;
      bm_s1_q   <= SYNC_RESET_VAL;
      bm_prev_q <= SYNC_RESET_VAL;
      bi_s0_q   <= SYNC_RESET_VAL;
      bi_s1_q   <= SYNC_RESET_VAL;
      bi_prev_q <= SYNC_RESET_VAL;
    end else begin
      bm_s0_q   <= btn_mode;
      bm_s1_q   <= bm_s0_q;
      bm_prev_q <= bm_s1_q;
      bi_s0_q   <= btn_inc;
      bi_s1_q   <= bi_s0_q;
      bi_prev_q <= bi_s1_q;
    end
  end

  assign mode_press = bm_s1_q & ~bm_prev_q;
  assign inc_press  = bi_s1_q & ~bi_prev_q;

  always_comb begin
    logic [8:0] s_n, m_n;
    logic [7:0] h_n;
    mode_d  = mode_q;
    h1_d    = h1_q;
    h0_d    = h0_q;
    m1_d    = m1_q;
    m0_d    = m0_q;
    s1_d    = s1_q;
    s0_d    = s0_q;
    carry_d = 1'b0;
    s_n     = inc60(s1_q, s0_q);
    m_n     = inc60(m1_q, m0_q);
    h_n     = inc24(h1_q, h0_q);
    case (mode_q)
      SET_HOUR: begin
        if (mode_press) begin
          mode_d = SET_MIN;
        end else if (inc_press) begin
          {h1_d, h0_d} = h_n;
        end
      end
      SET_MIN: begin
        if (mode_press) begin
          mode_d = RUN;
          s1_d   = 4'd0;
          s0_d   = 4'd0;
        end else if (inc_press) begin
          {m1_d, m0_d} = m_n[7:0];
        end
      end
      default: begin
        // 2'b11 is unreachable and behaves as RUN
        if (tick) begin
          {s1_d, s0_d} = s_n[7:0];
          if (s_n[8]) begin
            {m1_d, m0_d} = m_n[7:0];
            if (m_n[8]) begin
              {h1_d, h0_d} = h_n;
              carry_d = (h_n == 8'h00);
            end
          end
        end
        if (mode_press) mode_d = SET_HOUR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= RUN;
      h1_q    <= 4'd0;
      h0_q    <= 4'd0;
      m1_q    <= 4'd0;
      m0_q    <= 4'd0;
      s1_q    <= 4'd0;
      s0_q    <= 4'd0;
      carry_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      h1_q    <= h1_d;
      h0_q    <= h0_d;
      m1_q    <= m1_d;
      m0_q    <= m0_d;
      s1_q    <= s1_d;
      s0_q    <= s0_d;
      carry_q <= carry_d;
    end
  end

  assign hour1     = h1_q;
  assign hour0     = h0_q;
  assign min1      = m1_q;
  assign min0      = m0_q;
  assign sec1      = s1_q;
  assign sec0      = s0_q;
  assign mode      = mode_q;
  assign day_carry = carry_q;

endmodule

// File: tb/tb_tod_counter.sv
// Directed table-driven bench for tod_counter.
// Time is compared as packed BCD 24'hHHMMSS.
module tb_tod_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] hour1, hour0, min1, min0, sec1, sec0;
  logic [1:0] mode;
  logic       day_carry;

  tod_counter #(.SYNC_RESET_VAL(1'b1)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hour1(hour1), .hour0(hour0), .min1(min1), .min0(min0),
    .sec1(sec1), .sec0(sec0), .mode(mode), .day_carry(day_carry)
  );

  always #5 clk = ~clk;

  typedef enum int {OP_TICK, OP_MODE, OP_INC, OP_BOTH, OP_TICKMODE} op_e;
  typedef struct {
    op_e         op;
    int          n;
    logic [23:0] t;
    logic [1:0]  m;
    logic        c;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  int   carry_cnt = 0;
  int   carry_dbl = 0;
  logic carry_prev = 1'b0;

  function automatic logic [23:0] now();
    return {hour1, hour0, min1, min0, sec1, sec0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    repeat (3) edge1();
    btn_mode = 1'b0;
    repeat (3) edge1();
  endtask

  task automatic press_inc();
    btn_inc = 1'b1;
    repeat (3) edge1();
    btn_inc = 1'b0;
    repeat (3) edge1();
  endtask

  task automatic press_both();
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    repeat (3) edge1();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (3) edge1();
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) edge1();
    tick = 1'b0;
  endtask

  task automatic tick_mode();
    btn_mode = 1'b1;
    repeat (2) edge1();
    tick = 1'b1;
    edge1();
    tick = 1'b0;
  endtask

  task automatic add(input op_e op, input int n, input logic [23:0] t,
                     input logic [1:0] m, input logic c);
    vec_t v;
    v.op = op; v.n = n; v.t = t; v.m = m; v.c = c;
    vecs.push_back(v);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (day_carry) carry_cnt++;
      if (day_carry && carry_prev) carry_dbl++;
      carry_prev = day_carry;
    end else begin
      carry_prev = 1'b0;
    end
  end

  initial begin
    add(OP_TICK,      5, 24'h000005, 2'b00, 1'b0);
    add(OP_TICKMODE,  1, 24'h000006, 2'b01, 1'b0);
    add(OP_TICK,      3, 24'h000006, 2'b01, 1'b0);
    add(OP_INC,      22, 24'h220006, 2'b01, 1'b0);
    add(OP_INC,       1, 24'h230006, 2'b01, 1'b0);
    add(OP_INC,       1, 24'h000006, 2'b01, 1'b0);
    add(OP_INC,       1, 24'h010006, 2'b01, 1'b0);
    add(OP_BOTH,      1, 24'h010006, 2'b10, 1'b0);
    add(OP_INC,      58, 24'h015806, 2'b10, 1'b0);
    add(OP_INC,       1, 24'h015906, 2'b10, 1'b0);
    add(OP_INC,       1, 24'h010006, 2'b10, 1'b0);
    add(OP_INC,       1, 24'h010106, 2'b10, 1'b0);
    add(OP_TICK,      2, 24'h010106, 2'b10, 1'b0);
    add(OP_MODE,      1, 24'h010100, 2'b00, 1'b0);
    add(OP_TICK,     59, 24'h010159, 2'b00, 1'b0);
    add(OP_TICK,      1, 24'h010200, 2'b00, 1'b0);
    add(OP_MODE,      1, 24'h010200, 2'b01, 1'b0);
    add(OP_INC,      22, 24'h230200, 2'b01, 1'b0);
    add(OP_MODE,      1, 24'h230200, 2'b10, 1'b0);
    add(OP_INC,      57, 24'h235900, 2'b10, 1'b0);
    add(OP_MODE,      1, 24'h235900, 2'b00, 1'b0);
    add(OP_TICK,     59, 24'h235959, 2'b00, 1'b0);
    add(OP_TICK,      1, 24'h000000, 2'b00, 1'b1);
    add(OP_TICK,     59, 24'h000059, 2'b00, 1'b0);
    add(OP_TICK,      1, 24'h000100, 2'b00, 1'b0);
    add(OP_MODE,      1, 24'h000100, 2'b01, 1'b0);
    add(OP_MODE,      1, 24'h000100, 2'b10, 1'b0);
    add(OP_INC,      58, 24'h005900, 2'b10, 1'b0);
    add(OP_MODE,      1, 24'h005900, 2'b00, 1'b0);
    add(OP_TICK,     59, 24'h005959, 2'b00, 1'b0);
    add(OP_TICK,      1, 24'h010000, 2'b00, 1'b0);
    add(OP_MODE,      1, 24'h010000, 2'b01, 1'b0);
    add(OP_INC,      22, 24'h230000, 2'b01, 1'b0);
    add(OP_MODE,      1, 24'h230000, 2'b10, 1'b0);
    add(OP_INC,      59, 24'h235900, 2'b10, 1'b0);
    add(OP_MODE,      1, 24'h235900, 2'b00, 1'b0);
    add(OP_TICK,     59, 24'h235959, 2'b00, 1'b0);
    add(OP_TICKMODE,  1, 24'h000000, 2'b01, 1'b1);

    // reset with btn_mode held through release
    btn_mode = 1'b1;
    #3;
    chk("rst_time", 32'(now()), 32'h000000);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_carry", 32'(day_carry), 32'd0);
    repeat (2) edge1();
    reset = 1'b0;
    repeat (5) edge1();
    chk("held_btn_mode", 32'(mode), 32'd0);
    btn_mode = 1'b0;
    repeat (3) edge1();

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_TICK: ticks(vecs[i].n);
        OP_MODE: repeat (vecs[i].n) press_mode();
        OP_INC:  repeat (vecs[i].n) press_inc();
        OP_BOTH: press_both();
        default: tick_mode();
      endcase
      chk($sformatf("vec%0d_time", i), 32'(now()), 32'(vecs[i].t));
      chk($sformatf("vec%0d_mode", i), 32'(mode), 32'(vecs[i].m));
      chk($sformatf("vec%0d_carry", i), 32'(day_carry),
          32'(vecs[i].c));
      if (vecs[i].op == OP_TICKMODE) begin
        btn_mode = 1'b0;
        edge1();
        chk("carry_drop", 32'(day_carry), 32'd0);
        repeat (2) edge1();
      end
    end

    // back to RUN; seconds cleared
    press_mode();
    press_mode();
    chk("exit_set_time", 32'(now()), 32'h000000);
    chk("exit_set_mode", 32'(mode), 32'd0);

    // held inc gives one increment only
    press_mode();
    press_mode();
    btn_inc = 1'b1;
    repeat (1000) edge1();
    chk("hold_inc", 32'(now()), 32'h000100);
    btn_inc = 1'b0;
    repeat (3) edge1();
    press_mode();
    chk("hold_exit_mode", 32'(mode), 32'd0);

    // mid-count async reset at 12:34:56
    press_mode();
    repeat (12) press_inc();
    press_mode();
    repeat (33) press_inc();
    press_mode();
    ticks(56);
    chk("pre_rst_time", 32'(now()), 32'h123456);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_time", 32'(now()), 32'h000000);
    chk("async_rst_mode", 32'(mode), 32'd0);
    chk("async_rst_carry", 32'(day_carry), 32'd0);
    edge1();
    reset = 1'b0;
    repeat (3) edge1();

    // reset during set mode drops the partial edit
    press_mode();
    press_inc();
    chk("mid_set_time", 32'(now()), 32'h010000);
    #2 reset = 1'b1;
    #1;
    chk("mid_set_rst_time", 32'(now()), 32'h000000);
    chk("mid_set_rst_mode", 32'(mode), 32'd0);
    edge1();
    reset = 1'b0;
    repeat (3) edge1();
    chk("post_rst_mode", 32'(mode), 32'd0);

    chk("carry_pulses", 32'(carry_cnt), 32'd2);
    chk("carry_back_to_back", 32'(carry_dbl), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
